// File: rtl/ps2_scancode_decoder_if.sv
// Event port between the scan-code decoder and the CPU-side register block.
// The decoder is the master; the consumer drives evt_ready.
interface ps2_scancode_decoder_if;
    logic       evt_valid;
    logic       evt_ready;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [7:0] evt_ascii;

    modport master (output evt_valid, evt_code, evt_ext, evt_break, evt_ascii,
                    input  evt_ready);
    modport slave  (input  evt_valid, evt_code, evt_ext, evt_break, evt_ascii,
                    output evt_ready);
endinterface

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: pops receiver bytes, resolves E0/F0/E1 prefixes,
// tracks modifiers and Caps Lock, and presents one translated key event at a time.
//
// state  | meaning
// IDLE   | wait for a byte while the event register is empty
// POP    | pop strobe low for one cycle
// DECODE | interpret byte_r (or discard it while skip_cnt != 0)
// SKIP   | drain the Pause sequence, then emit the Pause event
module ps2_scancode_decoder (
    input  logic                          clk,
    input  logic                          clrn,
    input  logic [7:0]                    kbd_data,
    input  logic                          kbd_ready,
    input  logic                          kbd_overflow,
    output logic                          kbd_nextdata_n,
    ps2_scancode_decoder_if.master        evt,
    output logic                          mod_shift,
    output logic                          mod_ctrl,
    output logic                          mod_alt,
    output logic                          caps_lock,
    output logic                          err_ovf
);
    typedef enum logic [1:0] {IDLE = 2'd0, POP = 2'd1, DECODE = 2'd2, SKIP = 2'd3} state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_r;
    logic       ext_f, brk_f;
    logic [2:0] skip_cnt;
    logic       ovf_q, ovf_rise;
    logic       lshift, rshift, lctrl, rctrl, lalt, ralt, caps_held, caps_q, err_q;
    logic       valid_q, ext_q, brk_q;
    logic [7:0] code_q, ascii_q;
    logic       fetch, dec_skip, dec_byte, emit_key, emit_pause, is_prefix;

    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic ext,
                                            input logic shift, input logic ctrl,
                                            input logic caps);
        logic [7:0] lo, hi, r;
        logic       letter;
        lo = 8'h00;
        hi = 8'h00;
        if (ext) begin
            if (code == 8'h5A)      lo = 8'h0D;
            else if (code == 8'h4A) lo = 8'h2F;
            hi = lo;
        end else begin
            case (code)
                8'h1C: lo = 8'h61;  8'h32: lo = 8'h62;  8'h21: lo = 8'h63;
                8'h23: lo = 8'h64;  8'h24: lo = 8'h65;  8'h2B: lo = 8'h66;
                8'h34: lo = 8'h67;  8'h33: lo = 8'h68;  8'h43: lo = 8'h69;
                8'h3B: lo = 8'h6A;  8'h42: lo = 8'h6B;  8'h4B: lo = 8'h6C;
                8'h3A: lo = 8'h6D;  8'h31: lo = 8'h6E;  8'h44: lo = 8'h6F;
                8'h4D: lo = 8'h70;  8'h15: lo = 8'h71;  8'h2D: lo = 8'h72;
                8'h1B: lo = 8'h73;  8'h2C: lo = 8'h74;  8'h3C: lo = 8'h75;
                8'h2A: lo = 8'h76;  8'h1D: lo = 8'h77;  8'h22: lo = 8'h78;
                8'h35: lo = 8'h79;  8'h1A: lo = 8'h7A;
                8'h45: begin lo = 8'h30; hi = 8'h29; end
                8'h16: begin lo = 8'h31; hi = 8'h21; end
                8'h1E: begin lo = 8'h32; hi = 8'h40; end
                8'h26: begin lo = 8'h33; hi = 8'h23; end
                8'h25: begin lo = 8'h34; hi = 8'h24; end
                8'h2E: begin lo = 8'h35; hi = 8'h25; end
                8'h36: begin lo = 8'h36; hi = 8'h5E; end
                8'h3D: begin lo = 8'h37; hi = 8'h26; end
                8'h3E: begin lo = 8'h38; hi = 8'h2A; end
                8'h46: begin lo = 8'h39; hi = 8'h28; end
                8'h4E: begin lo = 8'h2D; hi = 8'h5F; end
                8'h55: begin lo = 8'h3D; hi = 8'h2B; end
                8'h54: begin lo = 8'h5B; hi = 8'h7B; end
                8'h5B: begin lo = 8'h5D; hi = 8'h7D; end
                8'h5D: begin lo = 8'h5C; hi = 8'h7C; end
                8'h4C: begin lo = 8'h3B; hi = 8'h3A; end
                8'h52: begin lo = 8'h27; hi = 8'h22; end
                8'h41: begin lo = 8'h2C; hi = 8'h3C; end
                8'h49: begin lo = 8'h2E; hi = 8'h3E; end
                8'h4A: begin lo = 8'h2F; hi = 8'h3F; end
                8'h0E: begin lo = 8'h60; hi = 8'h7E; end
                8'h29: begin lo = 8'h20; hi = 8'h20; end
                8'h5A: begin lo = 8'h0D; hi = 8'h0D; end
                8'h66: begin lo = 8'h08; hi = 8'h08; end
                8'h0D: begin lo = 8'h09; hi = 8'h09; end
                8'h76: begin lo = 8'h1B; hi = 8'h1B; end
                default: begin lo = 8'h00; hi = 8'h00; end
            endcase
        end
        // Only letters land in a..z; they follow caps/ctrl instead of the hi column.
        letter = (lo >= 8'h61) && (lo <= 8'h7A);
        if (letter) r = ctrl ? {3'b000, lo[4:0]} : ((shift ^ caps) ? lo - 8'h20 : lo);
        else        r = shift ? hi : lo;
        return r;
    endfunction

    assign ovf_rise  = kbd_overflow & ~ovf_q;
    assign is_prefix = byte_r inside {8'hF0, 8'hE0, 8'hE1};

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ovf_rise) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (kbd_ready && !valid_q) state_d = POP;
                POP:     state_d = DECODE;
                DECODE:  if (skip_cnt != 3'd0 || byte_r == 8'hE1) state_d = SKIP;
                         else                                      state_d = IDLE;
                SKIP:    if (skip_cnt == 3'd0) begin
                             if (!valid_q) state_d = IDLE;
                         end else if (kbd_ready) begin
                             state_d = POP;
                         end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        fetch      = 1'b0;
        dec_skip   = 1'b0;
        dec_byte   = 1'b0;
        emit_key   = 1'b0;
        emit_pause = 1'b0;
        if (!ovf_rise) begin
            case (state_q)
                IDLE:    fetch = kbd_ready && !valid_q;
                DECODE:  begin
                             dec_skip = (skip_cnt != 3'd0);
                             dec_byte = (skip_cnt == 3'd0);
                             emit_key = (skip_cnt == 3'd0) && !is_prefix;
                         end
                SKIP:    begin
                             fetch      = (skip_cnt != 3'd0) && kbd_ready;
                             emit_pause = (skip_cnt == 3'd0) && !valid_q;
                         end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            kbd_nextdata_n <= 1'b1;
            byte_r <= 8'h00;   ext_f <= 1'b0;   brk_f <= 1'b0;   skip_cnt <= 3'd0;
            ovf_q <= 1'b0;     err_q <= 1'b0;
            lshift <= 1'b0;    rshift <= 1'b0;  lctrl <= 1'b0;   rctrl <= 1'b0;
            lalt <= 1'b0;      ralt <= 1'b0;    caps_held <= 1'b0; caps_q <= 1'b0;
            valid_q <= 1'b0;   code_q <= 8'h00; ext_q <= 1'b0;   brk_q <= 1'b0;
            ascii_q <= 8'h00;
        end else begin
            ovf_q          <= kbd_overflow;
            kbd_nextdata_n <= ~fetch;
            if (fetch) byte_r <= kbd_data;
            if (ovf_rise) begin
                ext_f <= 1'b0;  brk_f <= 1'b0;  skip_cnt <= 3'd0;  err_q <= 1'b1;
                lshift <= 1'b0; rshift <= 1'b0; lctrl <= 1'b0; rctrl <= 1'b0;
                lalt <= 1'b0;   ralt <= 1'b0;   caps_held <= 1'b0;
            end else begin
                if (dec_skip) skip_cnt <= skip_cnt - 3'd1;
                if (dec_byte) begin
                    case (byte_r)
                        8'hF0:   brk_f <= 1'b1;
                        8'hE0:   ext_f <= 1'b1;
                        8'hE1:   begin ext_f <= 1'b0; brk_f <= 1'b0; skip_cnt <= 3'd7; end
                        default: begin ext_f <= 1'b0; brk_f <= 1'b0; end
                    endcase
                end
                if (emit_key) begin
                    if (!ext_f && byte_r == 8'h12) lshift <= ~brk_f;
                    if (!ext_f && byte_r == 8'h59) rshift <= ~brk_f;
                    if (byte_r == 8'h14) begin
                        if (ext_f) rctrl <= ~brk_f;
                        else       lctrl <= ~brk_f;
                    end
                    if (byte_r == 8'h11) begin
                        if (ext_f) ralt <= ~brk_f;
                        else       lalt <= ~brk_f;
                    end
                    // Typematic repeats keep caps_held set, so only the first make toggles.
                    if (!ext_f && byte_r == 8'h58) begin
                        if (brk_f) begin
                            caps_held <= 1'b0;
                        end else begin
                            caps_held <= 1'b1;
                            if (!caps_held) caps_q <= ~caps_q;
                        end
                    end
                end
            end
            if (emit_key) begin
                code_q  <= byte_r;
                ext_q   <= ext_f;
                brk_q   <= brk_f;
                ascii_q <= brk_f ? 8'h00 : ascii_of(byte_r, ext_f, mod_shift, mod_ctrl, caps_q);
            end else if (emit_pause) begin
                code_q  <= 8'hE1;
                ext_q   <= 1'b0;
                brk_q   <= 1'b0;
                ascii_q <= 8'h00;
            end
            if (emit_key || emit_pause) valid_q <= 1'b1;
            else if (evt.evt_ready)     valid_q <= 1'b0;
        end
    end

    assign mod_shift     = lshift | rshift;
    assign mod_ctrl      = lctrl | rctrl;
    assign mod_alt       = lalt | ralt;
    assign caps_lock     = caps_q;
    assign err_ovf       = err_q;
    assign evt.evt_valid = valid_q;
    assign evt.evt_code  = code_q;
    assign evt.evt_ext   = ext_q;
    assign evt.evt_break = brk_q;
    assign evt.evt_ascii = ascii_q;
endmodule
